flow_tuple_writer: RTL and testbench
====================================

Name: flow_tuple_writer

Overview:
Traffic-source block for the packet generator; the write-side counterpart of the tuple output queue. Given a base five-tuple and length profile, it synthesises a stream of {five-tuple, packet length} words and writes them into the queue's FIFO plane, throttled by fifo_nearly_full. The five-tuple cycles over a configurable number of flows and the length sweeps a configurable range.

Parameters:
PKT_TUPLE_WIDTH, 104, five-tuple width; layout is {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], proto[7:0]}, MSB first.
PKT_LEN_WIDTH, 16, packet length width in bytes.
FLOW_CNT_WIDTH, 16, width of the flow count and flow index.
PKT_CNT_WIDTH, 32, width of the packet count and sent counter.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
cfg_start  in  1  one-cycle pulse; starts a run (IDLE only)
cfg_stop  in  1  one-cycle pulse; aborts a run
cfg_base_tuple  in  PKT_TUPLE_WIDTH  flow-0 five-tuple
cfg_num_flows  in  FLOW_CNT_WIDTH  flow count; 0 is treated as 1
cfg_len_min  in  PKT_LEN_WIDTH  first and minimum length
cfg_len_max  in  PKT_LEN_WIDTH  maximum length
cfg_len_step  in  PKT_LEN_WIDTH  length increment per packet
cfg_pkt_count  in  PKT_CNT_WIDTH  packets to send; 0 means unlimited
fifo_data_out  out  PKT_TUPLE_WIDTH+PKT_LEN_WIDTH  {tuple, len}; len in the LSBs
fifo_wr_en  out  1  FIFO write strobe
fifo_nearly_full  in  1  FIFO back-pressure
busy  out  1  high in RUN
done  out  1  one-cycle pulse at end of a run
pkts_sent  out  PKT_CNT_WIDTH  words written in the current or last run

Behaviour:
- Reset: state IDLE. fifo_wr_en=0, fifo_data_out=0, busy=0, done=0, pkts_sent=0, flow_idx=0, cur_len=0. Reset during RUN drops fifo_wr_en on the same edge; no partial word is written.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - cfg_start=1 snapshots all cfg_* inputs into internal registers, clears pkts_sent, sets flow_idx=0 and cur_len=cfg_len_min, and moves to RUN.
  - cfg_stop is ignored.
- RUN:
  - Write condition at each edge: fifo_nearly_full=0, cfg_stop=0, and (pkt_count=0 or pkts_sent<pkt_count).
  - When the condition holds, the next cycle has fifo_wr_en=1 and fifo_data_out={tuple(flow_idx), cur_len}. Otherwise fifo_wr_en=0 next cycle.
  - Outputs are registered; the FIFO's nearly_full margin (at least 1 word) covers the one-cycle reaction latency.
  - cfg_start is ignored in RUN and DONE. Config inputs changing mid-run have no effect.
- Tuple generation:
  - src_ip = base.src_ip + flow_idx, modulo 2^32.
  - src_port = base.src_port + flow_idx[15:0], modulo 2^16.
  - dst_ip, dst_port and proto are taken unchanged from the base tuple.
- Per written word:
  - pkts_sent increments.
  - flow_idx increments, wrapping to 0 after num_flows-1.
  - cur_len advances to cur_len+len_step if that value is <= len_max. Otherwise it wraps to len_min.
  - The comparison is done at PKT_LEN_WIDTH+1 bits, so overflow also wraps to len_min.
  - If len_min>len_max or len_step=0, cur_len stays at len_min.
- RUN exit:
  - Finite count: when pkts_sent reaches pkt_count (counting the final write), go to DONE on the following edge.
  - Stop: cfg_stop in RUN suppresses the write for that edge and goes to DONE. Any write already registered from the previous edge still completes.
- DONE: lasts one cycle with done=1, then returns to IDLE. pkts_sent holds until the next start.
- busy is 1 exactly while the state is RUN.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins.

Test Plan:
1. Base tuple {0A000001, 0A000002, 1000, 0050, 06}, num_flows=3, len 64..66 step 1, count=5, nearly_full=0 -> five consecutive writes:
   - src_ip 0A000001, 0A000002, 0A000003, 0A000001, 0A000002
   - src_port 1000, 1001, 1002, 1000, 1001
   - len 64, 65, 66, 64, 65
   - then done pulse, pkts_sent=5, busy=0.
2. Same config with nearly_full held high for cycles 2-6 of the run -> fifo_wr_en=0 starting one cycle after assertion, resuming one cycle after deassertion. Still exactly 5 words, in correct sequence with no skips or duplicates.
3. count=0 (unlimited), cfg_stop pulsed after 10 writes -> at most one further in-flight write, done pulse, pkts_sent equals the number of fifo_wr_en cycles, back to IDLE.
4. len_min=1500, len_max=100, step=8 -> every word has len=1500. num_flows=0 -> single flow; src_ip and src_port are constant.
5. len_min=FFF0, len_max=FFFF, step=10 -> lengths alternate FFF0, FFF0 (overflow wraps to min); no out-of-range length is ever emitted.
6. resetn low for one cycle mid-run -> fifo_wr_en=0 and state IDLE after that edge, pkts_sent=0. A subsequent cfg_start restarts cleanly from flow 0 and len_min.

Source files
------------

// File: rtl/flow_tuple_writer.sv
// Packet-generator traffic source: emits {five-tuple, length} words into the
// tuple FIFO, cycling source address/port over N flows and sweeping the length.
module flow_tuple_writer #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int FLOW_CNT_WIDTH  = 16,
  parameter int PKT_CNT_WIDTH   = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     cfg_start,
  input  logic                                     cfg_stop,
  input  logic [PKT_TUPLE_WIDTH-1:0]               cfg_base_tuple,
  input  logic [FLOW_CNT_WIDTH-1:0]                cfg_num_flows,
  input  logic [PKT_LEN_WIDTH-1:0]                 cfg_len_min,
  input  logic [PKT_LEN_WIDTH-1:0]                 cfg_len_max,
  input  logic [PKT_LEN_WIDTH-1:0]                 cfg_len_step,
  input  logic [PKT_CNT_WIDTH-1:0]                 cfg_pkt_count,
  output logic [PKT_TUPLE_WIDTH+PKT_LEN_WIDTH-1:0] fifo_data_out,
  output logic                                     fifo_wr_en,
  input  logic                                     fifo_nearly_full,
  output logic                                     busy,
  output logic                                     done,
  output logic [PKT_CNT_WIDTH-1:0]                 pkts_sent
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                     state;

  logic [PKT_TUPLE_WIDTH-1:0] run_base;
  logic [FLOW_CNT_WIDTH-1:0]  run_num_flows;
  logic [PKT_LEN_WIDTH-1:0]   run_len_min;
  logic [PKT_LEN_WIDTH-1:0]   run_len_max;
  logic [PKT_LEN_WIDTH-1:0]   run_len_step;
  logic [PKT_CNT_WIDTH-1:0]   run_pkt_count;

  logic [FLOW_CNT_WIDTH-1:0]  flow_idx;
  logic [PKT_LEN_WIDTH-1:0]   cur_len;

  logic [PKT_LEN_WIDTH:0]     len_sum;
  logic [PKT_LEN_WIDTH-1:0]   len_next;
  logic [FLOW_CNT_WIDTH-1:0]  flow_next;
  logic [31:0]                src_ip;
  logic [15:0]                src_port;
  logic [PKT_TUPLE_WIDTH-1:0] tuple_cur;
  logic                       count_ok;
  logic                       count_hit;

  // Length sum is one bit wider so a 16-bit overflow also falls back to len_min.
  always_comb begin
    len_sum = {1'b0, cur_len} + {1'b0, run_len_step};
    if ((run_len_min > run_len_max) || (run_len_step == '0))
      len_next = run_len_min;
    else if (len_sum <= {1'b0, run_len_max})
      len_next = len_sum[PKT_LEN_WIDTH-1:0];
    else
      len_next = run_len_min;
  end

  always_comb begin
    if (flow_idx == run_num_flows - FLOW_CNT_WIDTH'(1))
      flow_next = '0;
    else
      flow_next = flow_idx + FLOW_CNT_WIDTH'(1);
  end

  always_comb begin
    src_ip    = run_base[103:72] + 32'(flow_idx);
    src_port  = run_base[39:24] + 16'(flow_idx);
    tuple_cur = {src_ip, run_base[71:40], src_port, run_base[23:0]};
  end

  assign count_ok  = (run_pkt_count == '0) || (pkts_sent < run_pkt_count);
  assign count_hit = !count_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      run_base      <= '0;
      run_num_flows <= FLOW_CNT_WIDTH'(1);
      run_len_min   <= '0;
      run_len_max   <= '0;
      run_len_step  <= '0;
      run_pkt_count <= '0;
      flow_idx      <= '0;
      cur_len       <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_data_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkts_sent     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fifo_wr_en <= 1'b0;
          done       <= 1'b0;
          if (cfg_start) begin
            run_base      <= cfg_base_tuple;
            run_num_flows <= (cfg_num_flows == '0) ? FLOW_CNT_WIDTH'(1) : cfg_num_flows;
            run_len_min   <= cfg_len_min;
            run_len_max   <= cfg_len_max;
            run_len_step  <= cfg_len_step;
            run_pkt_count <= cfg_pkt_count;
            flow_idx      <= '0;
            cur_len       <= cfg_len_min;
            pkts_sent     <= '0;
            busy          <= 1'b1;
            state         <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (cfg_stop || count_hit) begin
            fifo_wr_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else if (!fifo_nearly_full) begin
            fifo_wr_en    <= 1'b1;
            fifo_data_out <= {tuple_cur, cur_len};
            pkts_sent     <= pkts_sent + PKT_CNT_WIDTH'(1);
            flow_idx      <= flow_next;
            cur_len       <= len_next;
          end else begin
            fifo_wr_en <= 1'b0;
          end
        end

        ST_DONE: begin
          fifo_wr_en <= 1'b0;
          done       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          fifo_wr_en <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_tuple_writer.sv
// Directed bench for flow_tuple_writer: hand-computed word sequences, write
// masks and done timing for the flow/length sweep, back-pressure, stop and reset.
module tb_flow_tuple_writer;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_start;
  logic          cfg_stop;
  logic [103:0]  cfg_base_tuple;
  logic [15:0]   cfg_num_flows;
  logic [15:0]   cfg_len_min;
  logic [15:0]   cfg_len_max;
  logic [15:0]   cfg_len_step;
  logic [31:0]   cfg_pkt_count;
  logic [119:0]  fifo_data_out;
  logic          fifo_wr_en;
  logic          fifo_nearly_full;
  logic          busy;
  logic          done;
  logic [31:0]   pkts_sent;

  int            checks = 0;
  int            failures = 0;
  logic [119:0]  words[$];
  logic [63:0]   wr_mask;
  int            done_cyc;

  flow_tuple_writer #(
    .PKT_TUPLE_WIDTH(104),
    .PKT_LEN_WIDTH  (16),
    .FLOW_CNT_WIDTH (16),
    .PKT_CNT_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .cfg_base_tuple  (cfg_base_tuple),
    .cfg_num_flows   (cfg_num_flows),
    .cfg_len_min     (cfg_len_min),
    .cfg_len_max     (cfg_len_max),
    .cfg_len_step    (cfg_len_step),
    .cfg_pkt_count   (cfg_pkt_count),
    .fifo_data_out   (fifo_data_out),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_nearly_full(fifo_nearly_full),
    .busy            (busy),
    .done            (done),
    .pkts_sent       (pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] w(input logic [31:0] sip, input logic [15:0] sport,
                                     input logic [15:0] len);
    return {sip, 32'h0A000002, sport, 16'h0050, 8'h06, len};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] nf, input logic [15:0] lmin, input logic [15:0] lmax,
                     input logic [15:0] lstep, input logic [31:0] cnt);
    cfg_base_tuple = {32'h0A000001, 32'h0A000002, 16'h1000, 16'h0050, 8'h06};
    cfg_num_flows  = nf;
    cfg_len_min    = lmin;
    cfg_len_max    = lmax;
    cfg_len_step   = lstep;
    cfg_pkt_count  = cnt;
  endtask

  task automatic start_run(input string tag);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_eq({tag, "_busy_after_start"}, 128'(busy), 128'(1));
  endtask

  // Cycle c=0 is the first RUN cycle; nearly_full is high while nf_lo<=c<=nf_hi.
  task automatic run(input int nf_lo, input int nf_hi, input int stop_after, input int max_cyc);
    bit stopped = 0;
    words.delete();
    wr_mask  = '0;
    done_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      fifo_nearly_full = (c >= nf_lo) && (c <= nf_hi);
      cfg_stop = 1'b0;
      if (stop_after > 0 && words.size() == stop_after && !stopped) begin
        cfg_stop = 1'b1;
        stopped  = 1;
      end
      tick();
      cfg_stop = 1'b0;
      if (fifo_wr_en) begin
        words.push_back(fifo_data_out);
        wr_mask[c+1] = 1'b1;
      end
      if (done) begin
        done_cyc = c + 1;
        break;
      end
    end
    fifo_nearly_full = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [119:0] exp[$]);
    check_eq({tag, "_nwords"}, 128'(words.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size() && i < words.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), 128'(words[i]), 128'(exp[i]));
  endtask

  initial begin
    logic [119:0] exp[$];
    resetn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; fifo_nearly_full = 1'b0;
    cfg(16'd3, 16'd64, 16'd66, 16'd1, 32'd5);
    tick(); tick();
    check_eq("rst_wr_en", 128'(fifo_wr_en), 128'(0));
    check_eq("rst_data", 128'(fifo_data_out), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_pkts", 128'(pkts_sent), 128'(0));
    resetn = 1'b1;
    tick();

    // 1: three flows, length 64..66, five packets
    cfg(16'd3, 16'd64, 16'd66, 16'd1, 32'd5);
    start_run("t1");
    run(-1, -1, 0, 40);
    exp = '{w(32'h0A000001, 16'h1000, 16'd64), w(32'h0A000002, 16'h1001, 16'd65),
            w(32'h0A000003, 16'h1002, 16'd66), w(32'h0A000001, 16'h1000, 16'd64),
            w(32'h0A000002, 16'h1001, 16'd65)};
    check_words("t1", exp);
    check_eq("t1_mask", 128'(wr_mask), 128'(64'h3E));
    check_eq("t1_done_cyc", 128'(done_cyc), 128'(6));
    check_eq("t1_pkts", 128'(pkts_sent), 128'(5));
    check_eq("t1_busy_done", 128'(busy), 128'(0));
    tick();
    check_eq("t1_done_pulse", 128'(done), 128'(0));

    // 2: same run with back-pressure during cycles 2..6
    start_run("t2");
    run(2, 6, 0, 40);
    check_words("t2", exp);
    check_eq("t2_mask", 128'(wr_mask), 128'(64'h706));
    check_eq("t2_done_cyc", 128'(done_cyc), 128'(11));
    check_eq("t2_pkts", 128'(pkts_sent), 128'(5));
    tick();

    // 3: unlimited count, stop after ten writes
    cfg(16'd3, 16'd64, 16'd66, 16'd1, 32'd0);
    start_run("t3");
    run(-1, -1, 10, 40);
    check_eq("t3_nwords", 128'(words.size()), 128'(10));
    check_eq("t3_pkts_eq_writes", 128'(pkts_sent), 128'(words.size()));
    check_eq("t3_mask", 128'(wr_mask), 128'(64'h7FE));
    check_eq("t3_done_cyc", 128'(done_cyc), 128'(11));
    if (words.size() >= 10)
      check_eq("t3_word9", 128'(words[9]), 128'(w(32'h0A000001, 16'h1000, 16'd64)));
    tick();
    check_eq("t3_idle_busy", 128'(busy), 128'(0));
    check_eq("t3_idle_wr_en", 128'(fifo_wr_en), 128'(0));

    // 4: min > max pins length; zero flows acts as one flow
    cfg(16'd0, 16'd1500, 16'd100, 16'd8, 32'd4);
    start_run("t4");
    run(-1, -1, 0, 40);
    exp = '{w(32'h0A000001, 16'h1000, 16'd1500), w(32'h0A000001, 16'h1000, 16'd1500),
            w(32'h0A000001, 16'h1000, 16'd1500), w(32'h0A000001, 16'h1000, 16'd1500)};
    check_words("t4", exp);
    check_eq("t4_done_cyc", 128'(done_cyc), 128'(5));
    tick();

    // 5: length overflow past 16 bits wraps back to min
    cfg(16'd3, 16'hFFF0, 16'hFFFF, 16'h0010, 32'd3);
    start_run("t5");
    run(-1, -1, 0, 40);
    exp = '{w(32'h0A000001, 16'h1000, 16'hFFF0), w(32'h0A000002, 16'h1001, 16'hFFF0),
            w(32'h0A000003, 16'h1002, 16'hFFF0)};
    check_words("t5", exp);
    check_eq("t5_pkts", 128'(pkts_sent), 128'(3));
    tick();

    // 6: reset mid-run, then clean restart that ignores mid-run config changes
    cfg(16'd3, 16'd64, 16'd66, 16'd1, 32'd0);
    start_run("t6a");
    tick(); tick(); tick();
    check_eq("t6_running_wr_en", 128'(fifo_wr_en), 128'(1));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("t6_rst_wr_en", 128'(fifo_wr_en), 128'(0));
    check_eq("t6_rst_busy", 128'(busy), 128'(0));
    check_eq("t6_rst_pkts", 128'(pkts_sent), 128'(0));
    cfg(16'd3, 16'd64, 16'd66, 16'd1, 32'd2);
    start_run("t6b");
    cfg_base_tuple = '0; cfg_len_min = 16'd7; cfg_num_flows = 16'd1; cfg_pkt_count = 32'd9;
    run(-1, -1, 0, 40);
    exp = '{w(32'h0A000001, 16'h1000, 16'd64), w(32'h0A000002, 16'h1001, 16'd65)};
    check_words("t6", exp);
    check_eq("t6_done_cyc", 128'(done_cyc), 128'(3));
    check_eq("t6_pkts", 128'(pkts_sent), 128'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
